// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte sources.
// Frame-locked grants, burst limit, optional idle gap after each release.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tx_ready,
  output logic                   tx_wen,
  output logic [7:0]             tx_data,
  output logic                   grant_valid,
  output logic [2:0]             grant_id
);

  typedef enum logic [1:0] {ARB, SEND, HOLD, GAP} state_t;

  state_t      state, state_n;
  logic [2:0]  rr_ptr;
  logic [7:0]  burst_cnt;
  logic [7:0]  gap_cnt;
  logic        last_q;
  logic [7:0]  valid8, last8, ready8;
  logic [63:0] data64;
  logic [2:0]  pick;
  logic [3:0]  idx;
  logic        found, xfer, rel, at_limit;

  assign valid8   = 8'(req_valid);
  assign last8    = 8'(req_last);
  assign data64   = 64'(req_data);
  assign at_limit = (MAX_BURST != 0) &&
                    (burst_cnt == 8'(MAX_BURST));

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!found && valid8[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // HOLD spans the strobe cycle plus one settle cycle for the
  // transmitter's ready flag; tx_wen tells the two apart.
  always_comb begin
    state_n = state;
    ready8  = '0;
    xfer    = 1'b0;
    rel     = 1'b0;
    unique case (state)
      ARB: if (found) state_n = SEND;
      SEND: begin
        ready8[grant_id] = tx_ready & valid8[grant_id];
        xfer = tx_ready & valid8[grant_id];
        if (!valid8[grant_id]) rel = 1'b1;
        else if (xfer) state_n = HOLD;
      end
      HOLD: begin
        if (!tx_wen) begin
          if (last_q || at_limit) rel = 1'b1;
          else state_n = SEND;
        end
      end
      GAP: if (gap_cnt <= 8'd1) state_n = ARB;
      default: state_n = ARB;
    endcase
    if (rel) state_n = (GAP_CYCLES > 0) ? GAP : ARB;
  end

  assign req_ready = ready8[NUM_REQ-1:0];

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ARB;
    else state <= state_n;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wen      <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      last_q      <= 1'b0;
      rr_ptr      <= 3'(NUM_REQ - 1);
    end else begin
      tx_wen <= xfer;
      if (xfer) begin
        tx_data   <= data64[{grant_id, 3'b000} +: 8];
        burst_cnt <= burst_cnt + 8'd1;
        last_q    <= last8[grant_id];
      end
      if (state == ARB && found) begin
        grant_id    <= pick;
        grant_valid <= 1'b1;
      end
      if (rel) begin
        grant_valid <= 1'b0;
        rr_ptr      <= grant_id;
        burst_cnt   <= '0;
        gap_cnt     <= 8'(GAP_CYCLES);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule
